// File: rtl/wrapper_ahb_pkg.sv
// Shared definitions for the AHB-lite packet initiator.
// Holds the AHB encodings the manager drives, the FSM state type, the
// position of the last-alias address bit and a small sizing helper.
package wrapper_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // The last-alias bit sits this many places below the address width:
  // HADDRM[ADDRWIDTH-LAST_ALIAS_OFFSET] marks the final word of a last packet.
  localparam int LAST_ALIAS_OFFSET = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_ERR
  } state_t;

  // Width of a word index; a single-word packet still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrapper_ahb_packet_initiator_if.sv
// Bus bundle for the AHB-lite packet initiator.
// Carries the AHB-lite manager signals, the valid/ready packet stream,
// the data_req flow-control line and the busy/err status outputs.
//   master : the initiator's view (drives AHB address/data, ready, status)
//   slave  : the environment's view (drives HREADYM/HRESPM, packet stream, data_req)
interface wrapper_ahb_packet_initiator_if #(
  parameter int ADDRWIDTH   = 12,
  parameter int PACKETWIDTH = 512
);
  logic [ADDRWIDTH-1:0]   HADDRM;
  logic [1:0]             HTRANSM;
  logic [2:0]             HSIZEM;
  logic [2:0]             HBURSTM;
  logic [3:0]             HPROTM;
  logic                   HWRITEM;
  logic [31:0]            HWDATAM;
  logic                   HREADYM;
  logic                   HRESPM;
  logic [PACKETWIDTH-1:0] packet_data;
  logic                   packet_data_last;
  logic                   packet_data_valid;
  logic                   packet_data_ready;
  logic                   data_req;
  logic                   busy;
  logic                   err;

  modport master (
    output HADDRM, HTRANSM, HSIZEM, HBURSTM, HPROTM, HWRITEM, HWDATAM,
    output packet_data_ready, busy, err,
    input  HREADYM, HRESPM, packet_data, packet_data_last, packet_data_valid, data_req
  );

  modport slave (
    input  HADDRM, HTRANSM, HSIZEM, HBURSTM, HPROTM, HWRITEM, HWDATAM,
    input  packet_data_ready, busy, err,
    output HREADYM, HRESPM, packet_data, packet_data_last, packet_data_valid, data_req
  );

endinterface

// File: rtl/wrapper_packet_word_serialiser.sv
// Packet holding register and word walker.
// Captures a packet plus its last flag on i_load and presents one 32-bit
// word at a time, lowest word first; i_advance steps to the next word and
// i_flush discards whatever remains.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_load                  capture i_packet / i_last, restart at word 0
//   i_packet, i_last        packet payload and its last-of-message flag
//   i_advance               current word consumed
//   i_flush                 drop the remaining words
//   o_word                  current word
//   o_word_valid            a packet is loaded and words remain
//   o_word_is_final         current word is the packet's final word
//   o_next_is_final         the word after the current one is the final word
//   o_last                  last flag of the loaded packet
module wrapper_packet_word_serialiser
  import wrapper_ahb_pkg::*;
#(
  parameter int PACKETWIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [PACKETWIDTH-1:0] i_packet,
  input  logic                   i_last,
  input  logic                   i_advance,
  input  logic                   i_flush,
  output logic [31:0]            o_word,
  output logic                   o_word_valid,
  output logic                   o_word_is_final,
  output logic                   o_next_is_final,
  output logic                   o_last
);

  localparam int NWORDS = PACKETWIDTH / 32;
  localparam int IDXW   = idx_width(NWORDS);

  logic [PACKETWIDTH:0] r_hold;
  logic [IDXW-1:0]      r_idx;
  logic                 r_valid;
  logic [31:0]          w_words [NWORDS];

  // Payload register carries no reset; r_valid qualifies it.
  always_ff @(posedge i_clk) begin
    if (i_load) r_hold <= {i_last, i_packet};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (i_advance && r_valid) begin
      if (o_word_is_final) begin
        r_idx   <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx   <= r_idx + IDXW'(1);
      end
    end
  end

  for (genvar g = 0; g < NWORDS; g++) begin : g_words
    assign w_words[g] = r_hold[32*g +: 32];
  end

  assign o_word          = w_words[r_idx];
  assign o_word_valid    = r_valid;
  assign o_word_is_final = (r_idx == IDXW'(NWORDS - 1));
  assign o_next_is_final = (r_idx == IDXW'(NWORDS - 2));
  assign o_last          = r_hold[PACKETWIDTH];

endmodule

// File: rtl/wrapper_ahb_packet_initiator.sv
// AHB-lite manager that writes each accepted packet as NWORDS single-word
// NONSEQ writes into the accelerator wrapper's input window.
// A packet is taken only in IDLE while data_req is high; the final word of
// a last packet is written through the last-alias region so the target
// can recover packet_data_last. An ERROR response aborts the packet.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   bus            master view of the AHB-lite bus, the packet stream,
//                  data_req and the busy/err status
module wrapper_ahb_packet_initiator
  import wrapper_ahb_pkg::*;
#(
  parameter int          ADDRWIDTH   = 12,
  parameter int          PACKETWIDTH = 512,
  parameter int unsigned BASEADDR    = 0
) (
  input logic                           HCLK,
  input logic                           HRESETn,
  wrapper_ahb_packet_initiator_if.master bus
);

  localparam int NWORDS = PACKETWIDTH / 32;
  localparam logic [ADDRWIDTH-1:0] BASE_A  = ADDRWIDTH'(BASEADDR);
  localparam logic [ADDRWIDTH-1:0] ALIAS_A = ADDRWIDTH'(1) << (ADDRWIDTH - LAST_ALIAS_OFFSET);

  state_t                r_state;
  logic [1:0]            r_htrans;
  logic [ADDRWIDTH-1:0]  r_haddr;
  logic                  r_hwrite;
  logic [31:0]           r_hwdata;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_advance;
  logic                  w_flush;
  logic                  w_err_first;
  logic [31:0]           w_word;
  logic                  w_word_valid;
  logic                  w_word_is_final;
  logic                  w_next_is_final;
  logic                  w_last;
  logic [ADDRWIDTH-1:0]  w_first_addr;
  logic [ADDRWIDTH-1:0]  w_next_addr;

  assign bus.packet_data_ready = (r_state == ST_IDLE) && bus.data_req;
  assign w_accept    = bus.packet_data_ready && bus.packet_data_valid;
  // First cycle of the two-cycle ERROR response.
  assign w_err_first = bus.HRESPM && !bus.HREADYM;
  assign w_advance   = (r_state == ST_XFER) && bus.HREADYM;
  assign w_flush     = (r_state == ST_ERR) && bus.HREADYM;

  // Word 0 is already the final word when the packet is a single word.
  assign w_first_addr = BASE_A | (((NWORDS == 1) && bus.packet_data_last) ? ALIAS_A : '0);
  assign w_next_addr  = (r_haddr + ADDRWIDTH'(4)) | ((w_next_is_final && w_last) ? ALIAS_A : '0);

  wrapper_packet_word_serialiser #(
    .PACKETWIDTH (PACKETWIDTH)
  ) u_serialiser (
    .i_clk           (HCLK),
    .i_rst_n         (HRESETn),
    .i_load          (w_accept),
    .i_packet        (bus.packet_data),
    .i_last          (bus.packet_data_last),
    .i_advance       (w_advance),
    .i_flush         (w_flush),
    .o_word          (w_word),
    .o_word_valid    (w_word_valid),
    .o_word_is_final (w_word_is_final),
    .o_next_is_final (w_next_is_final),
    .o_last          (w_last)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= ST_IDLE;
      r_htrans <= HTRANS_IDLE;
      r_haddr  <= BASE_A;
      r_hwrite <= 1'b0;
      r_hwdata <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_XFER;
            r_htrans <= HTRANS_NONSEQ;
            r_hwrite <= 1'b1;
            r_haddr  <= w_first_addr;
            r_busy   <= 1'b1;
          end
        end
        ST_XFER: begin
          if (w_err_first) begin
            r_state  <= ST_ERR;
            r_htrans <= HTRANS_IDLE;
            r_hwrite <= 1'b0;
          end else if (bus.HREADYM && w_word_valid) begin
            // Address phase done: its word moves into the data phase.
            r_hwdata <= w_word;
            if (w_word_is_final) begin
              r_state  <= ST_DRAIN;
              r_htrans <= HTRANS_IDLE;
              r_hwrite <= 1'b0;
            end else begin
              r_haddr  <= w_next_addr;
            end
          end
        end
        ST_DRAIN: begin
          if (w_err_first) begin
            r_state <= ST_ERR;
          end else if (bus.HREADYM) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_ERR: begin
          if (bus.HREADYM) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_haddr <= BASE_A;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The pending address phase is withdrawn in the very cycle the ERROR
  // response starts, so HTRANSM cannot simply be the registered value.
  assign bus.HTRANSM = (((r_state == ST_XFER) || (r_state == ST_DRAIN)) && w_err_first)
                       ? HTRANS_IDLE : r_htrans;
  assign bus.HADDRM  = r_haddr;
  assign bus.HWRITEM = r_hwrite;
  assign bus.HWDATAM = r_hwdata;
  assign bus.HSIZEM  = HSIZE_WORD;
  assign bus.HBURSTM = HBURST_SINGLE;
  assign bus.HPROTM  = HPROT_DEFAULT;
  assign bus.busy    = r_busy;
  assign bus.err     = r_err;

endmodule
